// File: rtl/one_to_two_demux_buf_if.sv
// Stream bundle for the buffered 1-to-2 demux: one producer port and two consumer ports.
// slave is the demux's view of the bundle; master is the view from the producer and consumers.
interface one_to_two_demux_buf_if #(
  parameter int WIDTH = 2
);
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_a_data;
  logic             out_a_valid;
  logic             out_a_ready;
  logic [WIDTH-1:0] out_b_data;
  logic             out_b_valid;
  logic             out_b_ready;
  logic [1:0]       cnt_a;
  logic [1:0]       cnt_b;

  modport slave (
    input  in_data, in_sel, in_valid, out_a_ready, out_b_ready,
    output in_ready, out_a_data, out_a_valid, out_b_data, out_b_valid, cnt_a, cnt_b
  );

  modport master (
    output in_data, in_sel, in_valid, out_a_ready, out_b_ready,
    input  in_ready, out_a_data, out_a_valid, out_b_data, out_b_valid, cnt_a, cnt_b
  );
endinterface

// File: rtl/one_to_two_demux_buf.sv
// Buffered 1-to-2 stream demux: each word is routed by in_sel into one of two
// independent 2-entry FIFOs, so a stalled consumer only blocks its own side.
module one_to_two_demux_buf #(
  parameter int WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  one_to_two_demux_buf_if.slave bus
);

  localparam int NCH = 2;  // channel 0 = A, channel 1 = B
  localparam int DEPTH = 2;

  logic [WIDTH-1:0] mem_q    [NCH][DEPTH];
  logic [WIDTH-1:0] mem_d    [NCH][DEPTH];
  logic             wr_ptr_q [NCH];
  logic             wr_ptr_d [NCH];
  logic             rd_ptr_q [NCH];
  logic             rd_ptr_d [NCH];
  logic [1:0]       cnt_q    [NCH];
  logic [1:0]       cnt_d    [NCH];

  logic             push     [NCH];
  logic             pop      [NCH];
  logic             out_ready[NCH];
  logic             in_ready;

  assign out_ready[0] = bus.out_a_ready;
  assign out_ready[1] = bus.out_b_ready;

  // Acceptance looks only at registered occupancy, never at the consumer's
  // ready, so a full FIFO refuses a word even in a cycle where it pops.
  assign in_ready = bus.in_sel ? (cnt_q[1] != 2'd2) : (cnt_q[0] != 2'd2);

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path through
    // this block leaves a variable unassigned and no latch is inferred.
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    for (int c = 0; c < NCH; c++) begin
      push[c] = bus.in_valid && in_ready && (bus.in_sel == 1'(c));
      pop[c]  = (cnt_q[c] != 2'd0) && out_ready[c];
      if (push[c]) begin
        mem_d[c][wr_ptr_q[c]] = bus.in_data;
        wr_ptr_d[c]           = ~wr_ptr_q[c];
      end
      if (pop[c]) begin
        rd_ptr_d[c] = ~rd_ptr_q[c];
      end
      cnt_d[c] = cnt_q[c] + {1'b0, push[c]} - {1'b0, pop[c]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NCH; c++) begin
        // NOTE: the storage array is cleared on reset as well, because the head
        // word is visible on out_*_data and must read 0 straight out of reset.
        for (int e = 0; e < DEPTH; e++) begin
          mem_q[c][e] <= '0;
        end
        wr_ptr_q[c] <= 1'b0;
        rd_ptr_q[c] <= 1'b0;
        cnt_q[c]    <= 2'd0;
      end
    end else begin
      // NOTE: state registers use non-blocking assignment so every register
      // samples the pre-edge values computed above, independent of statement order.
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_a_data  = mem_q[0][rd_ptr_q[0]];
  assign bus.out_a_valid = (cnt_q[0] != 2'd0);
  assign bus.out_b_data  = mem_q[1][rd_ptr_q[1]];
  assign bus.out_b_valid = (cnt_q[1] != 2'd0);
  assign bus.cnt_a       = cnt_q[0];
  assign bus.cnt_b       = cnt_q[1];

endmodule
